// File: rtl/corescore_reset_pkg.sv
// Shared types and width helpers for the staggered reset sequencer.
package corescore_reset_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int unsigned width_for(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/corescore_heartbeat.sv
// Heartbeat LED: free-running HB_BITS counter, o_led toggles on each wrap while enabled.
module corescore_heartbeat #(
  parameter int unsigned HB_BITS = 24
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_led
);

  logic [HB_BITS-1:0] r_cnt;
  logic               r_led;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_led <= 1'b0;
    end else if (i_en) begin
      r_cnt <= r_cnt + HB_BITS'(1);
      if (&r_cnt) r_led <= ~r_led;
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/corescore_reset_seq.sv
// Staggered per-group reset release after a hold period, with a ready flag.
// Optional heartbeat LED enabled by defining CORESCORE_RESET_HEARTBEAT_EN.
module corescore_reset_seq
  import corescore_reset_pkg::*;
#(
  parameter int unsigned GROUPS  = 4,
  parameter int unsigned HOLD    = 16,
  parameter int unsigned STAGGER = 8,
  parameter int unsigned HB_BITS = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [GROUPS-1:0] o_rst,
  output logic              o_ready,
  output logic              o_led
);

  localparam int unsigned CNT_W = width_for(max_u(HOLD, STAGGER));
  localparam int unsigned IDX_W = width_for(GROUPS);

  localparam logic [CNT_W-1:0]  CNT_HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST      = IDX_W'(GROUPS - 1);
  localparam logic [GROUPS-1:0] GRP_ONE       = GROUPS'(1);

  if (GROUPS < 1 || HOLD < 1 || STAGGER < 1 || HB_BITS < 1) begin : g_bad_param
    $error("corescore_reset_seq: GROUPS, HOLD, STAGGER and HB_BITS must all be >= 1");
  end

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
  logic [IDX_W-1:0]  r_idx,   w_idx_nxt;
  logic [GROUPS-1:0] r_rst,   w_rst_nxt;
  logic              r_ready, w_ready_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst   <= '1;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_rst   <= w_rst_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Release bits are only ever cleared by masking, so release is monotonic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_rst_nxt   = r_rst;
    w_ready_nxt = r_ready;
    unique case (r_state)
      ST_HOLD: begin
        if (r_cnt == CNT_HOLD_LAST) begin
          w_cnt_nxt   = '0;
          w_rst_nxt   = r_rst & ~GRP_ONE;
          w_idx_nxt   = IDX_W'(1);
          w_state_nxt = (GROUPS == 1) ? ST_DONE : ST_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (r_cnt == CNT_STAG_LAST) begin
          w_cnt_nxt = '0;
          w_rst_nxt = r_rst & ~(GRP_ONE << r_idx);
          w_idx_nxt = r_idx + IDX_W'(1);
          if (r_idx == IDX_LAST) w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = ST_HOLD;
      end
    endcase
  end

  assign o_rst   = r_rst;
  assign o_ready = r_ready;

`ifdef CORESCORE_RESET_HEARTBEAT_EN
  // Enabled by o_ready so the first wrap lands 2^HB_BITS edges after ready rises.
  corescore_heartbeat #(
    .HB_BITS (HB_BITS)
  ) u_heartbeat (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (r_ready),
    .o_led (o_led)
  );
`else
  assign o_led = 1'b0;
`endif

endmodule

// File: tb/tb_corescore_reset_seq.sv
// Self-checking bench: directed and random i_rst patterns against a release-time model.
module tb_corescore_reset_seq;

  localparam int unsigned G0 = 4, H0 = 16, S0 = 8, HB0 = 4;
  localparam int unsigned G1 = 1, H1 = 1,  S1 = 1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [G0-1:0] o_rst_a;
  logic          o_ready_a, o_led_a;
  logic [G1-1:0] o_rst_b;
  logic          o_ready_b, o_led_b;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned n_zero   = 0;  // consecutive edges sampling i_rst=0 since last reset edge
  logic [31:0] prev_rst_a, prev_rst_b;
  logic        prev_in_rst;

  always #5 i_clk = ~i_clk;

  corescore_reset_seq #(
    .GROUPS  (G0),
    .HOLD    (H0),
    .STAGGER (S0),
    .HB_BITS (HB0)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .o_rst   (o_rst_a),
    .o_ready (o_ready_a),
    .o_led   (o_led_a)
  );

  corescore_reset_seq #(
    .GROUPS  (G1),
    .HOLD    (H1),
    .STAGGER (S1),
    .HB_BITS (HB0)
  ) dut_min (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .o_rst   (o_rst_b),
    .o_ready (o_ready_b),
    .o_led   (o_led_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t, n=%0d)", tag, got, exp, $time, n_zero);
    end
  endtask

  // Group k is released once n edges of i_rst=0 reach HOLD + k*STAGGER.
  function automatic logic [31:0] exp_rst(input int unsigned n, input int unsigned g,
                                          input int unsigned h, input int unsigned s);
    logic [31:0] v;
    v = '0;
    for (int unsigned k = 0; k < g; k++) if (n < h + k * s) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_ready(input int unsigned n, input int unsigned g,
                                     input int unsigned h, input int unsigned s);
    return n >= h + (g - 1) * s + 1;
  endfunction

  function automatic logic exp_led(input int unsigned n, input int unsigned g,
                                   input int unsigned h, input int unsigned s);
`ifdef CORESCORE_RESET_HEARTBEAT_EN
    int unsigned r;
    r = h + (g - 1) * s + 1;
    if (n < r) return 1'b0;
    return ((n - r) / (1 << HB0)) % 2 == 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input logic rst);
    prev_rst_a  = 32'(o_rst_a);
    prev_rst_b  = 32'(o_rst_b);
    prev_in_rst = rst;
    i_rst = rst;
    @(posedge i_clk);
    n_zero = rst ? 0 : n_zero + 1;
    @(negedge i_clk);
    check("rst_a",   32'(o_rst_a),   exp_rst(n_zero, G0, H0, S0));
    check("ready_a", 32'(o_ready_a), 32'(exp_ready(n_zero, G0, H0, S0)));
    check("led_a",   32'(o_led_a),   32'(exp_led(n_zero, G0, H0, S0)));
    check("rst_b",   32'(o_rst_b),   exp_rst(n_zero, G1, H1, S1));
    check("ready_b", 32'(o_ready_b), 32'(exp_ready(n_zero, G1, H1, S1)));
    check("led_b",   32'(o_led_b),   32'(exp_led(n_zero, G1, H1, S1)));
    if (!prev_in_rst) begin
      check("mono_a", 32'(o_rst_a) & ~prev_rst_a, 32'd0);
      check("mono_b", 32'(o_rst_b) & ~prev_rst_b, 32'd0);
    end
    check("rdy_impl_a", 32'(o_ready_a && (o_rst_a != '0)), 32'd0);
    check("rdy_impl_b", 32'(o_ready_b && (o_rst_b != '0)), 32'd0);
  endtask

  task automatic run_zero(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) step(1'b0);
  endtask

  initial begin
    // Nominal: reset held 5 cycles, then full sequence and some heartbeat time.
    for (int unsigned i = 0; i < 5; i++) step(1'b1);
    run_zero(60);
    // Reset pulse landing on edge 28 (mid-RELEASE).
    step(1'b1);
    run_zero(27);
    step(1'b1);
    run_zero(50);
    // Reset in DONE, then long run for several heartbeat periods.
    step(1'b1);
    run_zero(120);
    step(1'b1);
    run_zero(45);
    // Random reset patterns.
    for (int unsigned seg = 0; seg < 40; seg++) begin
      int unsigned nrst, nzero;
      nrst  = $urandom_range(3, 0);
      nzero = $urandom_range(70, 0);
      for (int unsigned i = 0; i < nrst; i++) step(1'b1);
      for (int unsigned i = 0; i < nzero; i++) step(($urandom_range(49, 0) == 0) ? 1'b1 : 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
